// File: rtl/vip_axi4_wr_arbiter.sv
// vip_axi4_wr_arbiter: shares one AXI4 write port (AW/W/B) between
// NR_OF_MASTERS_P requesters. One whole write transaction is granted at a
// time in round-robin order; the grant is held from AW selection until the
// B handshake, so at most one transaction is outstanding downstream.
// Optional protocol checker: define VIP_AXI4_WR_ARBITER_PROT_CHECK_EN.

// Per-master handshake gating: only the granted lane sees ready/bvalid.
module vip_axi4_wr_arbiter_lane (
  input  logic sel,
  input  logic aw_rdy,
  input  logic w_rdy,
  input  logic b_vld,
  output logic s_awready,
  output logic s_wready,
  output logic s_bvalid
);
  assign s_awready = sel & aw_rdy;
  assign s_wready  = sel & w_rdy;
  assign s_bvalid  = sel & b_vld;
endmodule

module vip_axi4_wr_arbiter #(
  parameter int NR_OF_MASTERS_P = 2,
  parameter int ID_WIDTH_P      = 4,
  parameter int ADDR_WIDTH_P    = 32,
  parameter int DATA_WIDTH_P    = 32,
  parameter int STRB_WIDTH_P    = DATA_WIDTH_P/8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NR_OF_MASTERS_P*ID_WIDTH_P-1:0]   s_awid,
  input  logic [NR_OF_MASTERS_P*ADDR_WIDTH_P-1:0] s_awaddr,
  input  logic [NR_OF_MASTERS_P*8-1:0]            s_awlen,
  input  logic [NR_OF_MASTERS_P*3-1:0]            s_awsize,
  input  logic [NR_OF_MASTERS_P*2-1:0]            s_awburst,
  input  logic [NR_OF_MASTERS_P-1:0]              s_awvalid,
  output logic [NR_OF_MASTERS_P-1:0]              s_awready,
  input  logic [NR_OF_MASTERS_P*DATA_WIDTH_P-1:0] s_wdata,
  input  logic [NR_OF_MASTERS_P*STRB_WIDTH_P-1:0] s_wstrb,
  input  logic [NR_OF_MASTERS_P-1:0]              s_wlast,
  input  logic [NR_OF_MASTERS_P-1:0]              s_wvalid,
  output logic [NR_OF_MASTERS_P-1:0]              s_wready,
  output logic [ID_WIDTH_P-1:0]                   s_bid,
  output logic [1:0]                              s_bresp,
  output logic [NR_OF_MASTERS_P-1:0]              s_bvalid,
  input  logic [NR_OF_MASTERS_P-1:0]              s_bready,
  output logic [ID_WIDTH_P-1:0]                   m_awid,
  output logic [ADDR_WIDTH_P-1:0]                 m_awaddr,
  output logic [7:0]                              m_awlen,
  output logic [2:0]                              m_awsize,
  output logic [1:0]                              m_awburst,
  output logic                                    m_awvalid,
  input  logic                                    m_awready,
  output logic [DATA_WIDTH_P-1:0]                 m_wdata,
  output logic [STRB_WIDTH_P-1:0]                 m_wstrb,
  output logic                                    m_wlast,
  output logic                                    m_wvalid,
  input  logic                                    m_wready,
  input  logic [ID_WIDTH_P-1:0]                   m_bid,
  input  logic [1:0]                              m_bresp,
  input  logic                                    m_bvalid,
  output logic                                    m_bready,
  output logic [NR_OF_MASTERS_P-1:0]              gnt_o,
  output logic                                    prot_err_o
);

  localparam int N     = NR_OF_MASTERS_P;
  localparam int IDX_W = $clog2(N);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, req_idx, rr_nxt;
  logic [IDX_W:0]     cand;
  logic               req_found;
  logic [N-1:0]       gnt_new;
  logic               aw_done, w_done;

  logic [ID_WIDTH_P-1:0]   sel_awid;
  logic [ADDR_WIDTH_P-1:0] sel_awaddr;
  logic [7:0]              sel_awlen;
  logic [2:0]              sel_awsize;
  logic [1:0]              sel_awburst;
  logic                    sel_awvalid;
  logic [DATA_WIDTH_P-1:0] sel_wdata;
  logic [STRB_WIDTH_P-1:0] sel_wstrb;
  logic                    sel_wlast, sel_wvalid, sel_bready;

  logic act, rsp, aw_rdy, w_rdy, b_vld;
  logic aw_hs, w_hs, w_last_hs, b_hs;

  // Round-robin search: first requester at or after rr_ptr, wrapping upward.
  always_comb begin
    req_found = 1'b0;
    req_idx   = rr_ptr;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!req_found && s_awvalid[cand[IDX_W-1:0]]) begin
        req_found = 1'b1;
        req_idx   = cand[IDX_W-1:0];
      end
    end
    rr_nxt  = (req_idx == IDX_W'(N-1)) ? '0 : req_idx + 1'b1;
    gnt_new = '0;
    gnt_new[req_idx] = 1'b1;
  end

  // Grant mux: one-hot select, all-zero when nothing is granted.
  always_comb begin
    sel_awid    = '0;
    sel_awaddr  = '0;
    sel_awlen   = '0;
    sel_awsize  = '0;
    sel_awburst = '0;
    sel_awvalid = 1'b0;
    sel_wdata   = '0;
    sel_wstrb   = '0;
    sel_wlast   = 1'b0;
    sel_wvalid  = 1'b0;
    sel_bready  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt_o[i]) begin
        sel_awid    = s_awid[i*ID_WIDTH_P +: ID_WIDTH_P];
        sel_awaddr  = s_awaddr[i*ADDR_WIDTH_P +: ADDR_WIDTH_P];
        sel_awlen   = s_awlen[i*8 +: 8];
        sel_awsize  = s_awsize[i*3 +: 3];
        sel_awburst = s_awburst[i*2 +: 2];
        sel_awvalid = s_awvalid[i];
        sel_wdata   = s_wdata[i*DATA_WIDTH_P +: DATA_WIDTH_P];
        sel_wstrb   = s_wstrb[i*STRB_WIDTH_P +: STRB_WIDTH_P];
        sel_wlast   = s_wlast[i];
        sel_wvalid  = s_wvalid[i];
        sel_bready  = s_bready[i];
      end
    end
  end

  assign act = (state == ACTIVE);
  assign rsp = (state == RESP);

  // AW and W run independently; each closes once its handshake completes.
  assign m_awvalid = act & sel_awvalid & ~aw_done;
  assign aw_rdy    = act & m_awready & ~aw_done;
  assign m_wvalid  = act & sel_wvalid & ~w_done;
  assign w_rdy     = act & m_wready & ~w_done;
  assign m_bready  = rsp & sel_bready;
  assign b_vld     = rsp & m_bvalid;

  assign aw_hs     = m_awvalid & m_awready;
  assign w_hs      = m_wvalid & m_wready;
  assign w_last_hs = w_hs & sel_wlast;
  assign b_hs      = rsp & m_bvalid & sel_bready;

  assign m_awid    = sel_awid;
  assign m_awaddr  = sel_awaddr;
  assign m_awlen   = sel_awlen;
  assign m_awsize  = sel_awsize;
  assign m_awburst = sel_awburst;
  assign m_wdata   = sel_wdata;
  assign m_wstrb   = sel_wstrb;
  assign m_wlast   = sel_wlast;
  assign s_bid     = m_bid;
  assign s_bresp   = m_bresp;

  for (genvar g = 0; g < N; g++) begin : g_lane
    vip_axi4_wr_arbiter_lane u_lane (
      .sel       (gnt_o[g]),
      .aw_rdy    (aw_rdy),
      .w_rdy     (w_rdy),
      .b_vld     (b_vld),
      .s_awready (s_awready[g]),
      .s_wready  (s_wready[g]),
      .s_bvalid  (s_bvalid[g])
    );
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: a transaction finishes when AW, last W and B are all done.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|s_awvalid) state_nxt = ACTIVE;
      ACTIVE:  if ((aw_done | aw_hs) && (w_done | w_last_hs)) state_nxt = RESP;
      RESP:    if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, round-robin pointer and per-channel completion flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_o   <= '0;
      rr_ptr  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|s_awvalid) begin
          gnt_o  <= gnt_new;
          rr_ptr <= rr_nxt;
        end
        ACTIVE: if (state_nxt == RESP) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (aw_hs)     aw_done <= 1'b1;
          if (w_last_hs) w_done  <= 1'b1;
        end
        RESP: if (b_hs) gnt_o <= '0;
        default: gnt_o <= '0;
      endcase
    end
  end

`ifdef VIP_AXI4_WR_ARBITER_PROT_CHECK_EN
  logic [8:0]  beat_cnt;
  logic [7:0]  len_q, len_cur;
  logic [16:0] span;
  logic        aw_known, bad_aw, bad_late, bad_last, prot_err_q;

  // W beats seen before the AW are judged once the AW is captured.
  assign aw_known = aw_done | aw_hs;
  assign len_cur  = aw_done ? len_q : sel_awlen;
  assign span     = 17'(sel_awaddr[11:0]) + ((17'(sel_awlen) + 17'd1) << sel_awsize);
  assign bad_aw   = aw_hs & ((sel_awburst == 2'b11) |
                             ((sel_awburst == 2'b01) & (span > 17'd4096)));
  assign bad_late = aw_hs & w_done & (beat_cnt != ({1'b0, sel_awlen} + 9'd1));
  assign bad_last = w_last_hs & aw_known & (beat_cnt != {1'b0, len_cur});
  assign prot_err_o = prot_err_q;

  // Beat counter, captured AW length and the sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt   <= '0;
      len_q      <= '0;
      prot_err_q <= 1'b0;
    end else begin
      if (aw_hs) len_q <= sel_awlen;
      if (state == IDLE || state_nxt == RESP) beat_cnt <= '0;
      else if (w_hs)                          beat_cnt <= beat_cnt + 9'd1;
      if (bad_aw | bad_late | bad_last) prot_err_q <= 1'b1;
    end
  end
`else
  assign prot_err_o = 1'b0;
`endif

endmodule
